// File: rtl/lpm_tcam_pkg.sv
// Shared types for the LPM route table: default geometry, entry record and mask helper.
package lpm_tcam_pkg;

  localparam int LPM_WIDTH = 32;
  localparam int LPM_DEPTH = 16;
  localparam int LPM_IF_W  = 4;
  localparam int LPM_PL_W  = $clog2(LPM_WIDTH + 1);

  typedef struct packed {
    logic                  valid;
    logic [LPM_WIDTH-1:0]  net;
    logic [LPM_WIDTH-1:0]  mask;
    logic [LPM_PL_W-1:0]   prefix_len;
    logic [LPM_WIDTH-1:0]  next_hop;
    logic [LPM_IF_W-1:0]   if_idx;
  } lpm_entry_t;

  // Top plen bits set; plen >= WIDTH yields an all-ones mask.
  function automatic logic [LPM_WIDTH-1:0] lpm_mask(input logic [LPM_PL_W-1:0] plen);
    return ~({LPM_WIDTH{1'b1}} >> plen);
  endfunction

endpackage

// File: rtl/lpm_prio_sel.sv
// Longest-prefix priority select: binary tree over match[], ties go to the lower index.
// Purely combinational, no backpressure.
module lpm_prio_sel #(
  parameter int DEPTH = 16,
  parameter int PL_W  = 6,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]      match,
  input  logic [DEPTH*PL_W-1:0] prefix_len,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  hit
);

  // Heap-ordered nodes: leaves at DEPTH..2*DEPTH-1, root at 1.
  logic              nv [1:2*DEPTH-1];
  logic [PL_W-1:0]   nl [1:2*DEPTH-1];
  logic [IDX_W-1:0]  nx [1:2*DEPTH-1];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      nv[DEPTH+i] = match[i];
      nl[DEPTH+i] = prefix_len[i*PL_W +: PL_W];
      nx[DEPTH+i] = IDX_W'(i);
    end
    for (int n = DEPTH - 1; n >= 1; n--) begin
      // Right child only wins with a strictly longer prefix, so the lower index keeps ties.
      if (nv[2*n+1] && (!nv[2*n] || (nl[2*n+1] > nl[2*n]))) begin
        nl[n] = nl[2*n+1];
        nx[n] = nx[2*n+1];
      end else begin
        nl[n] = nl[2*n];
        nx[n] = nx[2*n];
      end
      nv[n] = nv[2*n] | nv[2*n+1];
    end
    win_idx = nx[1];
    hit     = nv[1];
  end

endmodule

// File: rtl/lpm_tcam.sv
// LPM route table, optional counters under LPM_STATS_EN.
// Latency 2 cycles, one lookup per cycle; no backpressure, single-cycle write port.
module lpm_tcam
  import lpm_tcam_pkg::*;
#(
  parameter int WIDTH = LPM_WIDTH,
  parameter int DEPTH = LPM_DEPTH,
  parameter int IF_W  = LPM_IF_W,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int PL_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [WIDTH-1:0] lk_addr,
  output logic             res_valid,
  output logic             res_hit,
  output logic [WIDTH-1:0] res_next_hop,
  output logic [IF_W-1:0]  res_if_idx,
  output logic [PL_W-1:0]  res_prefix_len,
  output logic [IDX_W-1:0] res_index,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic             wr_entry_valid,
  input  logic [WIDTH-1:0] wr_net,
  input  logic [PL_W-1:0]  wr_prefix_len,
  input  logic [WIDTH-1:0] wr_next_hop,
  input  logic [IF_W-1:0]  wr_if_idx,
  output logic             wr_err,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_misses
);

  lpm_entry_t              tbl [DEPTH];
  logic [DEPTH-1:0]        lk_match;
  logic [DEPTH-1:0]        s1_match;
  logic                    s1_vld;
  logic [DEPTH*PL_W-1:0]   plen_vec;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_hit;
  logic                    wr_bad;

  assign wr_bad = wr_en && wr_entry_valid && (wr_prefix_len > PL_W'(WIDTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_bad;
      if (wr_en && !wr_bad) begin
        if (wr_entry_valid) begin
          tbl[wr_index] <= '{valid:      1'b1,
                             net:        wr_net & lpm_mask(wr_prefix_len),
                             mask:       lpm_mask(wr_prefix_len),
                             prefix_len: wr_prefix_len,
                             next_hop:   wr_next_hop,
                             if_idx:     wr_if_idx};
        end else begin
          tbl[wr_index].valid <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    lk_match = '0;
    plen_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_match[i] = tbl[i].valid && ((lk_addr & tbl[i].mask) == tbl[i].net);
      plen_vec[i*PL_W +: PL_W] = tbl[i].prefix_len;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld   <= 1'b0;
      s1_match <= '0;
    end else begin
      s1_vld   <= lk_valid;
      s1_match <= lk_match;
    end
  end

  // Selection uses the entry fields live in this cycle; the match vector is frozen from stage 1.
  lpm_prio_sel #(
    .DEPTH (DEPTH),
    .PL_W  (PL_W),
    .IDX_W (IDX_W)
  ) u_prio_sel (
    .match      (s1_match),
    .prefix_len (plen_vec),
    .win_idx    (win_idx),
    .hit        (win_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid      <= 1'b0;
      res_hit        <= 1'b0;
      res_next_hop   <= '0;
      res_if_idx     <= '0;
      res_prefix_len <= '0;
      res_index      <= '0;
    end else begin
      res_valid <= s1_vld;
      if (s1_vld) begin
        res_hit <= win_hit;
        if (win_hit) begin
          res_next_hop   <= tbl[win_idx].next_hop;
          res_if_idx     <= tbl[win_idx].if_idx;
          res_prefix_len <= tbl[win_idx].prefix_len;
          res_index      <= win_idx;
        end else begin
          res_next_hop   <= '0;
          res_if_idx     <= '0;
          res_prefix_len <= '0;
          res_index      <= '0;
        end
      end
    end
  end

`ifdef LPM_STATS_EN
  logic [31:0] lk_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lk_cnt   <= '0;
      miss_cnt <= '0;
    end else if (res_valid) begin
      if (lk_cnt != '1) lk_cnt <= lk_cnt + 32'd1;
      if (!res_hit && (miss_cnt != '1)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign stat_lookups = lk_cnt;
  assign stat_misses  = miss_cnt;
`else
  assign stat_lookups = '0;
  assign stat_misses  = '0;
`endif

endmodule

// File: tb/tb_lpm_tcam.sv
// Bench for lpm_tcam: directed route scenarios plus random traffic against an arithmetic LPM model.
module tb_lpm_tcam;

  localparam int W = 32, D = 16, IFW = 4, IW = 4, PLW = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           lk_valid;
  logic [W-1:0]   lk_addr;
  logic           res_valid, res_hit;
  logic [W-1:0]   res_next_hop;
  logic [IFW-1:0] res_if_idx;
  logic [PLW-1:0] res_prefix_len;
  logic [IW-1:0]  res_index;
  logic           wr_en, wr_entry_valid, wr_err;
  logic [IW-1:0]  wr_index;
  logic [W-1:0]   wr_net, wr_next_hop;
  logic [PLW-1:0] wr_prefix_len;
  logic [IFW-1:0] wr_if_idx;
  logic [31:0]    stat_lookups, stat_misses;

  lpm_tcam dut (
    .clk(clk), .rst_n(rst_n), .lk_valid(lk_valid), .lk_addr(lk_addr),
    .res_valid(res_valid), .res_hit(res_hit), .res_next_hop(res_next_hop),
    .res_if_idx(res_if_idx), .res_prefix_len(res_prefix_len), .res_index(res_index),
    .wr_en(wr_en), .wr_index(wr_index), .wr_entry_valid(wr_entry_valid),
    .wr_net(wr_net), .wr_prefix_len(wr_prefix_len), .wr_next_hop(wr_next_hop),
    .wr_if_idx(wr_if_idx), .wr_err(wr_err),
    .stat_lookups(stat_lookups), .stat_misses(stat_misses)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic           hit;
    logic [W-1:0]   nh;
    logic [IFW-1:0] ifi;
    logic [PLW-1:0] pl;
    logic [IW-1:0]  idx;
    int             cyc;
  } exp_t;

  exp_t q[$];
  exp_t me;

  // Reference table: plain arrays, prefix length kept as an integer.
  logic           m_vld [D];
  logic [W-1:0]   m_net [D];
  logic [W-1:0]   m_nh  [D];
  logic [IFW-1:0] m_if  [D];
  int             m_pl  [D];

  int pass_cnt = 0, total_cnt = 0;
  int obs_lk = 0, obs_miss = 0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [W-1:0] tmask(input int p);
    if (p == 0) return '0;
    return ~((32'h1 << (32 - p)) - 32'h1);
  endfunction

  function automatic exp_t model_lookup(input logic [W-1:0] a);
    exp_t e;
    int best = -1;
    e.hit = 0; e.nh = '0; e.ifi = '0; e.pl = '0; e.idx = '0; e.cyc = 0;
    for (int i = 0; i < D; i++)
      if (m_vld[i] && ((a & tmask(m_pl[i])) == m_net[i]) && (m_pl[i] > best)) begin
        best  = m_pl[i];
        e.idx = IW'(i);
      end
    if (best >= 0) begin
      e.hit = 1'b1;
      e.nh  = m_nh[e.idx];
      e.ifi = m_if[e.idx];
      e.pl  = PLW'(best);
    end
    return e;
  endfunction

  task automatic lookup(input logic [W-1:0] a);
    exp_t e;
    lk_valid = 1'b1;
    lk_addr  = a;
    e = model_lookup(a);
    e.cyc = cyc;
    q.push_back(e);
  endtask

  task automatic wr(input int idx, input logic v, input logic [W-1:0] net, input int pl,
                    input logic [W-1:0] nh, input logic [IFW-1:0] ifi);
    wr_en = 1'b1; wr_index = IW'(idx); wr_entry_valid = v; wr_net = net;
    wr_prefix_len = PLW'(pl); wr_next_hop = nh; wr_if_idx = ifi;
  endtask

  // Advance one clock, then fold any write that was presented into the model.
  task automatic step();
    logic bad;
    @(posedge clk); #1;
    if (wr_en) begin
      bad = wr_entry_valid && (int'(wr_prefix_len) > W);
      chk("wr_err", wr_err, bad);
      if (!bad) begin
        if (wr_entry_valid) begin
          m_vld[wr_index] = 1'b1;
          m_pl[wr_index]  = int'(wr_prefix_len);
          m_net[wr_index] = wr_net & tmask(int'(wr_prefix_len));
          m_nh[wr_index]  = wr_next_hop;
          m_if[wr_index]  = wr_if_idx;
        end else m_vld[wr_index] = 1'b0;
      end
      prev_err = bad;
    end else begin
      if (prev_err) chk("wr_err_single_pulse", wr_err, 0);
      prev_err = 1'b0;
    end
    wr_en = 1'b0;
    lk_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    chk("drain_timeout_pending", q.size(), 0);
    step(); step();
  endtask

  task automatic check_stats();
`ifdef LPM_STATS_EN
    chk("stat_lookups", stat_lookups, obs_lk);
    chk("stat_misses", stat_misses, obs_miss);
`else
    chk("stat_lookups_tied", stat_lookups, 0);
    chk("stat_misses_tied", stat_misses, 0);
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_hit"}, res_hit, 0);
    chk({tag, "_res_next_hop"}, res_next_hop, 0);
    chk({tag, "_res_if_idx"}, res_if_idx, 0);
    chk({tag, "_res_prefix_len"}, res_prefix_len, 0);
    chk({tag, "_res_index"}, res_index, 0);
    chk({tag, "_wr_err"}, wr_err, 0);
    chk({tag, "_stat_lookups"}, stat_lookups, 0);
    chk({tag, "_stat_misses"}, stat_misses, 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_result: res_valid=1 with no request outstanding (cycle %0d)", cyc);
      end else begin
        me = q.pop_front();
        chk("latency", cyc, me.cyc + 2);
        chk("res_hit", res_hit, me.hit);
        chk("res_next_hop", res_next_hop, me.nh);
        chk("res_if_idx", res_if_idx, me.ifi);
        chk("res_prefix_len", res_prefix_len, me.pl);
        chk("res_index", res_index, me.idx);
        obs_lk++;
        if (!me.hit) obs_miss++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rnd, base;
    logic [7:0]   top;
    int           j;

    for (int i = 0; i < D; i++) begin
      m_vld[i] = 0; m_net[i] = '0; m_nh[i] = '0; m_if[i] = '0; m_pl[i] = 0;
    end
    rst_n = 1'b0; lk_valid = 0; lk_addr = '0; wr_en = 0; wr_index = '0;
    wr_entry_valid = 0; wr_net = '0; wr_prefix_len = '0; wr_next_hop = '0; wr_if_idx = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    step();

    // Empty table
    lookup(32'hC0A8_0101); step();

    // Nested prefixes and default route
    wr(0, 1, 32'hC0A8_0000, 24, 32'h0A00_0001, 4'd1); step();
    wr(1, 1, 32'hC0A8_0000, 27, 32'h0A00_0002, 4'd2); step();
    wr(2, 1, 32'h0000_0000, 0,  32'h0A00_0003, 4'd3); step();
    lookup(32'hC0A8_000A); step();
    lookup(32'hC0A8_003C); step();
    lookup(32'h0A00_000A); step();

    // Duplicate prefix: lower index wins, then falls back after invalidation
    wr(5, 1, 32'h0A00_0000, 8, 32'h0B00_0005, 4'd4); step();
    wr(3, 1, 32'h0A12_3456, 8, 32'h0B00_0003, 4'd7); step();
    lookup(32'h0A00_0002); step();
    wr(3, 0, 32'h0, 0, 32'h0, 4'd0); step();
    lookup(32'h0A00_0002); step();

    // Write and lookup in the same cycle, then the following cycle
    wr(4, 1, 32'hC0A8_0020, 27, 32'h0C00_0004, 4'd5);
    lookup(32'hC0A8_0021); step();
    lookup(32'hC0A8_0021); step();

    // Rejected prefix length leaves the table alone
    wr(0, 1, 32'h0101_0101, 33, 32'hFFFF_FFFF, 4'd15); step();
    lookup(32'hC0A8_003C); step();
    step();

    // Back-to-back lookups
    for (int i = 0; i < 12; i++) begin
      rnd = $urandom();
      if (i % 3 == 0) rnd[31:24] = 8'd172;
      else if (i % 3 == 1) rnd[31:8] = 24'hC0A800;
      lookup(rnd); step();
    end
    drain();
    check_stats();

    // Random table rewrite followed by random lookups
    for (int i = 0; i < 24; i++) begin
      rnd = $urandom();
      case ($urandom_range(0, 2))
        0: top = 8'd10;
        1: top = 8'd192;
        default: top = 8'd172;
      endcase
      rnd[31:24] = top;
      wr($urandom_range(0, D - 1), ($urandom_range(0, 4) != 0), rnd, $urandom_range(0, 34),
         $urandom(), IFW'($urandom_range(0, 15)));
      step();
    end
    step();
    for (int i = 0; i < 40; i++) begin
      rnd  = $urandom();
      j    = $urandom_range(0, D - 1);
      base = m_net[j];
      if (i % 2 == 0) rnd = base ^ {24'h0, rnd[7:0]};
      lookup(rnd); step();
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    check_stats();

    // Reset asserted while results are in flight
    wr(15, 1, 32'h0, 0, 32'hDEAD_BEEF, 4'd9); step();
    lookup(32'h0102_0304); step();
    lookup(32'h0506_0708); step();
    lookup(32'h090A_0B0C); step();
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    q.delete();
    for (int i = 0; i < D; i++) m_vld[i] = 0;
    obs_lk = 0; obs_miss = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    lookup(32'h0102_0304); step();
    drain();
    check_stats();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
